// File: rtl/intr_ctrl_nest.sv
// intr_ctrl_nest: fast/normal interrupt controller for NUM_IO channels.
// Requests are latched per vector (pend, or defer when their channel is busy),
// masked, prioritised (lowest vector wins) and presented through intr/ack/eoi.
// A fast vector may pre-empt a normal one, so the in-service stack is 2 deep.
//
// state | meaning
// IDLE  | nothing in service, nothing presented
// REQ   | intr/intr_vec presented and frozen until ack or eoi
// SERV  | one vector in service (level 1)
// NEST  | fast vector nested over a normal one (level 2)
module intr_ctrl_nest #(
   parameter int NUM_IO = 3,
   parameter int VEC_W  = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_IO-1:0]   fintr_req,
   input  logic [NUM_IO-1:0]   intr_req,
   input  logic                mask_ld,
   input  logic [2*NUM_IO-1:0] mask_in,
   input  logic                intr_ack,
   input  logic                eoi,
   output logic                intr,
   output logic [VEC_W-1:0]    intr_vec,
   output logic [2*NUM_IO-1:0] isr_out,
   output logic [NUM_IO-1:0]   io_enable,
   output logic [1:0]          nest_level
);
   localparam int NV = 2*NUM_IO;

   typedef enum logic [1:0] {IDLE, REQ, SERV, NEST} state_t;

   state_t           state;
   logic [NV-1:0]    pend, defer, mask, isr;
   logic [NV-1:0]    pend_nx, defer_nx, isr_nx;
   logic [NV-1:0]    elig;
   logic [VEC_W-1:0] stk0, stk1, top_vec, win_vec;
   logic [1:0]       level;
   logic             win_valid, do_ack, do_eoi;
   int               ack_ch, eoi_ch;

   function automatic int chan_of(input logic [VEC_W-1:0] v);
      int i;
      i = int'(v);
      return (i < NUM_IO) ? i : i - NUM_IO;
   endfunction

   function automatic logic [NUM_IO-1:0] onehot(input int c);
      logic [NUM_IO-1:0] r;
      r = '0;
      for (int i = 0; i < NUM_IO; i++)
         if (i == c) r[i] = 1'b1;
      return r;
   endfunction

   // Innermost vector, the vectors allowed to pre-empt it, and the winner
   always_comb begin
      top_vec = (level == 2'd2) ? stk1 : stk0;
      elig    = '0;
      if (level == 2'd0)
         elig = '1;
      else if (level == 2'd1 && int'(top_vec) >= NUM_IO)
         elig[NUM_IO-1:0] = '1;
      win_valid = 1'b0;
      win_vec   = '0;
      for (int v = NV-1; v >= 0; v--) begin
         if (pend[v] && !mask[v] && elig[v]) begin
            win_valid = 1'b1;
            win_vec   = VEC_W'(v);
         end
      end
   end

   // Next pend/defer/in-service bits from ack, eoi and newly raised requests
   always_comb begin
      do_eoi   = eoi && (level != 2'd0);
      do_ack   = intr_ack && (state == REQ) && !do_eoi;
      ack_ch   = chan_of(intr_vec);
      eoi_ch   = chan_of(top_vec);
      isr_nx   = isr;
      pend_nx  = pend;
      defer_nx = defer;
      for (int v = 0; v < NV; v++) begin
         if (do_ack && v == int'(intr_vec)) begin
            isr_nx[v]  = 1'b1;
            pend_nx[v] = 1'b0;
         end
         if (do_eoi && v == int'(top_vec))
            isr_nx[v] = 1'b0;
      end
      for (int c = 0; c < NUM_IO; c++) begin
         // the other vector of an acked channel must wait for its EOI
         if (do_ack && c == ack_ch) begin
            if (int'(intr_vec) < NUM_IO) begin
               if (pend[NUM_IO+c]) begin
                  defer_nx[NUM_IO+c] = 1'b1;
                  pend_nx[NUM_IO+c]  = 1'b0;
               end
            end else if (pend[c]) begin
               defer_nx[c] = 1'b1;
               pend_nx[c]  = 1'b0;
            end
         end
         if (do_eoi && c == eoi_ch) begin
            pend_nx[c]         = pend_nx[c] | defer[c];
            pend_nx[NUM_IO+c]  = pend_nx[NUM_IO+c] | defer[NUM_IO+c];
            defer_nx[c]        = 1'b0;
            defer_nx[NUM_IO+c] = 1'b0;
         end
         // channel busy is judged after this edge's ack/eoi takes effect
         if (fintr_req[c] && !mask[c]) begin
            if (isr_nx[c] || isr_nx[NUM_IO+c]) defer_nx[c] = 1'b1;
            else                              pend_nx[c]  = 1'b1;
         end
         if (intr_req[c] && !mask[NUM_IO+c]) begin
            if (isr_nx[c] || isr_nx[NUM_IO+c]) defer_nx[NUM_IO+c] = 1'b1;
            else                              pend_nx[NUM_IO+c]  = 1'b1;
         end
      end
   end

   // Request latches, in-service bits and mask register
   always_ff @(posedge clk) begin
      if (reset) begin
         pend  <= '0;
         defer <= '0;
         isr   <= '0;
         mask  <= '0;
      end else begin
         pend  <= pend_nx;
         defer <= defer_nx;
         isr   <= isr_nx;
         if (mask_ld) mask <= mask_in;
      end
   end

   // Handshake FSM with in-service stack and registered CPU-facing outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         intr      <= 1'b0;
         intr_vec  <= '0;
         stk0      <= '0;
         stk1      <= '0;
         level     <= 2'd0;
         io_enable <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (win_valid) begin
                  intr     <= 1'b1;
                  intr_vec <= win_vec;
                  state    <= REQ;
               end
            end
            REQ: begin
               if (do_eoi) begin
                  // outer ISR ended before the pre-empting vector was taken
                  intr      <= 1'b0;
                  level     <= level - 2'd1;
                  io_enable <= (level == 2'd2) ? onehot(chan_of(stk0)) : '0;
                  state     <= (level == 2'd2) ? SERV : IDLE;
               end else if (do_ack) begin
                  intr      <= 1'b0;
                  level     <= level + 2'd1;
                  io_enable <= onehot(chan_of(intr_vec));
                  if (level == 2'd0) begin
                     stk0  <= intr_vec;
                     state <= SERV;
                  end else begin
                     stk1  <= intr_vec;
                     state <= NEST;
                  end
               end
            end
            SERV: begin
               if (do_eoi) begin
                  level     <= 2'd0;
                  io_enable <= '0;
                  state     <= IDLE;
               end else if (win_valid) begin
                  intr     <= 1'b1;
                  intr_vec <= win_vec;
                  state    <= REQ;
               end
            end
            NEST: begin
               if (do_eoi) begin
                  level     <= 2'd1;
                  io_enable <= onehot(chan_of(stk0));
                  state     <= SERV;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign isr_out    = isr;
   assign nest_level = level;

endmodule

// File: tb/tb_intr_ctrl_nest.sv
// Testbench for intr_ctrl_nest: directed scenarios plus random traffic.
// A behavioural model (sets of pending/deferred vectors and a queue used as
// the service stack) predicts each presentation; a monitor pops predictions
// whenever the DUT raises intr.
module tb_intr_ctrl_nest;
   localparam int N  = 3;
   localparam int NV = 2*N;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [N-1:0]  fintr_req = '0, intr_req = '0;
   logic          mask_ld = 1'b0;
   logic [NV-1:0] mask_in = '0;
   logic          intr_ack = 1'b0, eoi = 1'b0;
   logic          intr;
   logic [2:0]    intr_vec;
   logic [NV-1:0] isr_out;
   logic [N-1:0]  io_enable;
   logic [1:0]    nest_level;

   intr_ctrl_nest #(.NUM_IO(N), .VEC_W(3)) dut (
      .clk(clk), .reset(reset), .fintr_req(fintr_req), .intr_req(intr_req),
      .mask_ld(mask_ld), .mask_in(mask_in), .intr_ack(intr_ack), .eoi(eoi),
      .intr(intr), .intr_vec(intr_vec), .isr_out(isr_out),
      .io_enable(io_enable), .nest_level(nest_level)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // reference model
   bit m_pend[NV], m_defer[NV], m_mask[NV];
   int m_stk[$];
   bit m_intr;
   int m_vec;
   int exp_q[$];
   int seen_q[$];
   bit track = 1'b0;
   bit prev_intr = 1'b0;

   task automatic chk(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
      end
   endtask

   function automatic void model_clear();
      for (int v = 0; v < NV; v++) begin
         m_pend[v] = 0; m_defer[v] = 0; m_mask[v] = 0;
      end
      m_stk.delete();
      m_intr = 0;
      m_vec  = 0;
   endfunction

   function automatic void model_step(input logic [N-1:0] f, input logic [N-1:0] n,
                                      input logic a, input logic e, input logic ml,
                                      input logic [NV-1:0] mi, input logic rst);
      bit eoi_do, ack_do, new_intr, allowed, busy;
      int new_vec, w, c, p;
      bit req[NV];
      if (rst) begin
         model_clear();
         return;
      end
      for (int i = 0; i < N; i++) begin
         req[i]   = f[i];
         req[N+i] = n[i];
      end
      eoi_do   = e && (m_stk.size() > 0);
      ack_do   = a && m_intr && !eoi_do;
      new_intr = m_intr;
      new_vec  = m_vec;
      if (m_intr) begin
         if (eoi_do || ack_do) new_intr = 0;
      end else if (!eoi_do) begin
         w = -1;
         for (int v = 0; v < NV; v++) begin
            allowed = (m_stk.size() == 0) ||
                      (m_stk.size() == 1 && m_stk[0] >= N && v < N);
            if (w < 0 && m_pend[v] && !m_mask[v] && allowed) w = v;
         end
         if (w >= 0) begin
            new_intr = 1;
            new_vec  = w;
            exp_q.push_back(w);
         end
      end
      if (ack_do) begin
         m_stk.push_back(m_vec);
         m_pend[m_vec] = 0;
         p = (m_vec < N) ? m_vec + N : m_vec - N;
         if (m_pend[p]) begin
            m_pend[p]  = 0;
            m_defer[p] = 1;
         end
      end
      if (eoi_do) begin
         c = m_stk.pop_back() % N;
         if (m_defer[c])   begin m_pend[c]   = 1; m_defer[c]   = 0; end
         if (m_defer[c+N]) begin m_pend[c+N] = 1; m_defer[c+N] = 0; end
      end
      for (int v = 0; v < NV; v++) begin
         if (req[v] && !m_mask[v]) begin
            busy = 0;
            foreach (m_stk[k]) if (m_stk[k] % N == v % N) busy = 1;
            if (busy) m_defer[v] = 1;
            else      m_pend[v]  = 1;
         end
      end
      if (ml) for (int v = 0; v < NV; v++) m_mask[v] = mi[v];
      m_intr = new_intr;
      m_vec  = new_vec;
   endfunction

   task automatic check_state();
      int s, io;
      s = 0;
      foreach (m_stk[k]) s |= (1 << m_stk[k]);
      io = (m_stk.size() > 0) ? (1 << (m_stk[m_stk.size()-1] % N)) : 0;
      chk("intr", int'(intr), int'(m_intr));
      if (m_intr) chk("intr_vec", int'(intr_vec), m_vec);
      chk("isr_out", int'(isr_out), s);
      chk("nest_level", int'(nest_level), m_stk.size());
      chk("io_enable", int'(io_enable), io);
   endtask

   task automatic tick_full(input logic [N-1:0] f, input logic [N-1:0] n,
                            input logic a, input logic e, input logic ml,
                            input logic [NV-1:0] mi, input logic rst);
      fintr_req = f; intr_req = n; intr_ack = a; eoi = e;
      mask_ld = ml; mask_in = mi; reset = rst;
      model_step(f, n, a, e, ml, mi, rst);
      @(posedge clk);
      #1;
      check_state();
   endtask

   task automatic tick(input logic [N-1:0] f, input logic [N-1:0] n,
                       input logic a, input logic e);
      tick_full(f, n, a, e, 1'b0, '0, 1'b0);
   endtask

   // CPU that acks whatever is presented and ends any ISR otherwise
   task automatic serve(input int cycles);
      for (int i = 0; i < cycles; i++)
         tick('0, '0, intr, (nest_level != 2'd0) && !intr);
   endtask

   task automatic wait_intr(input int max_cycles);
      int k;
      k = 0;
      while (!intr && k < max_cycles) begin
         tick('0, '0, 1'b0, 1'b0);
         k++;
      end
      if (!intr) begin
         checks++;
         failures++;
         $display("FAIL wait_intr: got timeout expected intr within %0d cycles", max_cycles);
      end
   endtask

   // scoreboard monitor: every rising intr consumes one prediction
   always @(negedge clk) begin
      if (intr && !prev_intr) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL present_unexpected: got vec %0d expected none", intr_vec);
         end else begin
            chk("present_vec", int'(intr_vec), exp_q.pop_front());
         end
         if (track) seen_q.push_back(int'(intr_vec));
      end
      prev_intr = intr;
   end

   initial begin
      model_clear();
      // reset state
      tick_full('0, '0, 0, 0, 0, '0, 1'b1);
      tick_full('0, '0, 0, 0, 0, '0, 1'b1);
      chk("rst_intr", int'(intr), 0);
      chk("rst_vec", int'(intr_vec), 0);
      chk("rst_isr", int'(isr_out), 0);
      chk("rst_io", int'(io_enable), 0);
      chk("rst_level", int'(nest_level), 0);

      // single fast request on channel 1, two-edge latency
      tick(3'b010, '0, 0, 0);
      chk("t1_latched_no_intr", int'(intr), 0);
      tick('0, '0, 0, 0);
      chk("t1_intr", int'(intr), 1);
      chk("t1_vec", int'(intr_vec), 1);
      tick('0, '0, 1, 0);
      chk("t1_isr", int'(isr_out), 6'b000010);
      chk("t1_io", int'(io_enable), 3'b010);
      chk("t1_level", int'(nest_level), 1);
      tick('0, '0, 0, 1);
      chk("t1_eoi_isr", int'(isr_out), 0);
      chk("t1_eoi_io", int'(io_enable), 0);
      chk("t1_eoi_level", int'(nest_level), 0);

      // simultaneous fast/normal: order 2, 3, 5
      track = 1'b1;
      seen_q.delete();
      tick(3'b100, 3'b101, 0, 0);
      serve(14);
      track = 1'b0;
      chk("t2_count", seen_q.size(), 3);
      if (seen_q.size() == 3) begin
         chk("t2_first", seen_q[0], 2);
         chk("t2_second", seen_q[1], 3);
         chk("t2_third", seen_q[2], 5);
      end

      // fast 0 nests over normal 4
      tick('0, 3'b010, 0, 0);
      wait_intr(4);
      chk("t3_vec4", int'(intr_vec), 4);
      tick('0, '0, 1, 0);
      tick(3'b001, '0, 0, 0);
      tick('0, '0, 0, 0);
      chk("t3_pre_intr", int'(intr), 1);
      chk("t3_pre_vec", int'(intr_vec), 0);
      tick('0, '0, 1, 0);
      chk("t3_level2", int'(nest_level), 2);
      chk("t3_io_inner", int'(io_enable), 3'b001);
      chk("t3_isr", int'(isr_out), 6'b010001);
      tick('0, '0, 0, 1);
      chk("t3_io_outer", int'(io_enable), 3'b010);
      chk("t3_level1", int'(nest_level), 1);
      tick('0, '0, 0, 1);
      chk("t3_level0", int'(nest_level), 0);

      // re-request of an in-service fast vector is deferred until eoi
      tick(3'b001, '0, 0, 0);
      wait_intr(4);
      tick('0, '0, 1, 0);
      tick(3'b001, '0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         tick('0, '0, 0, 0);
         chk("t4_deferred_quiet", int'(intr), 0);
      end
      tick('0, '0, 0, 1);
      chk("t4_eoi_intr", int'(intr), 0);
      tick('0, '0, 0, 0);
      chk("t4_represent", int'(intr), 1);
      chk("t4_represent_vec", int'(intr_vec), 0);
      serve(4);

      // masked request is never latched
      tick_full('0, '0, 0, 0, 1'b1, 6'b000001, 1'b0);
      tick(3'b001, '0, 0, 0);
      for (int i = 0; i < 3; i++) tick('0, '0, 0, 0);
      chk("t5_masked", int'(intr), 0);
      tick_full('0, '0, 0, 0, 1'b1, 6'b000000, 1'b0);
      for (int i = 0; i < 3; i++) tick('0, '0, 0, 0);
      chk("t5_unmasked_quiet", int'(intr), 0);
      tick(3'b001, '0, 0, 0);
      tick('0, '0, 0, 0);
      chk("t5_intr", int'(intr), 1);
      chk("t5_vec", int'(intr_vec), 0);
      serve(4);

      // eoi together with ack while fast 0 is presented over normal 4
      tick('0, 3'b010, 0, 0);
      wait_intr(4);
      tick('0, '0, 1, 0);
      tick(3'b001, '0, 0, 0);
      wait_intr(4);
      tick('0, '0, 1, 1);
      chk("t6_intr", int'(intr), 0);
      chk("t6_isr", int'(isr_out), 0);
      chk("t6_level", int'(nest_level), 0);
      tick('0, '0, 0, 0);
      chk("t6_repres", int'(intr), 1);
      chk("t6_repres_vec", int'(intr_vec), 0);
      serve(4);

      // reset mid-service
      tick('0, 3'b001, 0, 0);
      wait_intr(4);
      tick(3'b110, '0, 1, 0);
      tick_full('0, '0, 0, 0, 0, '0, 1'b1);
      chk("t7_isr", int'(isr_out), 0);
      chk("t7_level", int'(nest_level), 0);
      chk("t7_intr", int'(intr), 0);
      for (int i = 0; i < 3; i++) tick('0, '0, 0, 0);
      chk("t7_lost", int'(intr), 0);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         logic [N-1:0]  f, n;
         logic [NV-1:0] mi;
         for (int b = 0; b < N; b++) begin
            f[b] = ($urandom_range(0, 7) == 0);
            n[b] = ($urandom_range(0, 7) == 0);
         end
         mi = NV'($urandom_range(0, 63) & $urandom_range(0, 63));
         tick_full(f, n, ($urandom_range(0, 2) == 0), ($urandom_range(0, 5) == 0),
                   ($urandom_range(0, 39) == 0), mi, ($urandom_range(0, 399) == 0));
      end

      tick_full('0, '0, 0, 0, 1'b1, '0, 1'b0);
      serve(40);
      chk("drain_pending_predictions", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
